// File: rtl/cnn_pkg.sv
// Shared constants, FSM state type and window offset helper for the CNN window scheduler.
package cnn_pkg;

    localparam int IMG_W_DEF = 32'd28;
    localparam int IMG_H_DEF = 32'd28;
    localparam int AW_DEF    = 32'd10;
    localparam int WIN_N     = 32'd3;
    localparam int WIN_K     = 32'd9;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_FETCH   = 3'd2,
        ST_CAP     = 3'd3,
        ST_PRESENT = 3'd4
    } win_sched_state_t;

    // Offset of window tap k from the window origin: ky*img_w + kx, built from adds only.
    function automatic int unsigned win_off(input logic [3:0] k, input int unsigned img_w);
        int unsigned off;
        case (k)
            4'd0:    off = 32'd0;
            4'd1:    off = 32'd1;
            4'd2:    off = 32'd2;
            4'd3:    off = img_w;
            4'd4:    off = img_w + 32'd1;
            4'd5:    off = img_w + 32'd2;
            4'd6:    off = img_w + img_w;
            4'd7:    off = img_w + img_w + 32'd1;
            4'd8:    off = img_w + img_w + 32'd2;
            default: off = 32'd0;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/cnn_win_addr_gen.sv
// Window origin counters, incremental row base and tap address generation.
module cnn_win_addr_gen
    import cnn_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    input  logic [3:0]    k_sel,
    output logic [AW-1:0] addr,
    output logic [AW-1:0] fetch_lim,
    output logic          last_win
);

    localparam logic [AW-1:0] C_LAST  = AW'(IMG_W - 32'd3);
    localparam logic [AW-1:0] R_LAST  = AW'(IMG_H - 32'd3);
    localparam logic [AW-1:0] W_STEP  = AW'(IMG_W);
    localparam logic [AW-1:0] LIM_OFF = AW'(IMG_W + IMG_W + 32'd2);
    localparam logic [AW-1:0] ONE     = AW'(32'd1);

    logic [AW-1:0] r_r;
    logic [AW-1:0] c_r;
    logic [AW-1:0] row_base_r;
    logic [AW-1:0] off_s;

    assign off_s     = AW'(win_off(k_sel, IMG_W));
    assign addr      = row_base_r + c_r + off_s;
    // Bottom-right pixel of the window at the current origin; it must already be written.
    assign fetch_lim = row_base_r + c_r + LIM_OFF;
    assign last_win  = (r_r == R_LAST) && (c_r == C_LAST);

    // Origin stepping: column advance, row wrap adds one image width to the row base.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_r        <= {AW{1'b0}};
            c_r        <= {AW{1'b0}};
            row_base_r <= {AW{1'b0}};
        end else if (adv) begin
            if (c_r == C_LAST) begin
                c_r        <= {AW{1'b0}};
                r_r        <= r_r + ONE;
                row_base_r <= row_base_r + W_STEP;
            end else begin
                c_r <= c_r + ONE;
            end
        end
    end

endmodule

// File: rtl/cnn_win_sched.sv
// 3x3 window scheduler: waits for pixel data, fetches 9 bits from RAM, presents the window.
module cnn_win_sched
    import cnn_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frm_strt,
    input  logic [AW-1:0] wr_ptr,
    output logic          ram_rd,
    output logic [AW-1:0] ram_addr,
    input  logic          ram_dout,
    output logic [8:0]    win,
    output logic          win_vld,
    input  logic          win_rdy,
    output logic          busy,
    output logic          frm_done
);

    win_sched_state_t state_r;
    logic [3:0]       k_r;
    logic [8:0]       win_r;
    logic             win_vld_r;
    logic             ram_rd_r;
    logic [AW-1:0]    ram_addr_r;
    logic             busy_r;
    logic             frm_done_r;

    logic [3:0]       k_sel_s;
    logic [AW-1:0]    addr_s;
    logic [AW-1:0]    fetch_lim_s;
    logic             last_s;
    logic             hs_s;
    logic             wait_go_s;

    assign hs_s      = (state_r == ST_PRESENT) && win_vld_r && win_rdy;
    assign wait_go_s = fetch_lim_s < wr_ptr;

    // Tap index whose address is loaded at the next edge: tap 0 on FETCH entry, k+1 within FETCH.
    always_comb begin
        k_sel_s = 4'd0;
        if (state_r == ST_FETCH) begin
            k_sel_s = k_r + 4'd1;
        end else begin
            k_sel_s = 4'd0;
        end
    end

    cnn_win_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .AW    (AW)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .clr       (frm_strt || (hs_s && last_s)),
        .adv       (hs_s && !frm_strt && !last_s),
        .k_sel     (k_sel_s),
        .addr      (addr_s),
        .fetch_lim (fetch_lim_s),
        .last_win  (last_s)
    );

    // Scheduler FSM with capture register and registered outputs; rst beats frm_strt beats handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            k_r        <= 4'd0;
            win_r      <= 9'd0;
            win_vld_r  <= 1'b0;
            ram_rd_r   <= 1'b0;
            ram_addr_r <= {AW{1'b0}};
            busy_r     <= 1'b0;
            frm_done_r <= 1'b0;
        end else if (frm_strt) begin
            state_r    <= ST_WAIT;
            k_r        <= 4'd0;
            win_r      <= 9'd0;
            win_vld_r  <= 1'b0;
            ram_rd_r   <= 1'b0;
            ram_addr_r <= {AW{1'b0}};
            busy_r     <= 1'b1;
            frm_done_r <= 1'b0;
        end else begin
            frm_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    busy_r    <= 1'b0;
                    ram_rd_r  <= 1'b0;
                    win_vld_r <= 1'b0;
                end
                ST_WAIT: begin
                    if (wait_go_s) begin
                        state_r    <= ST_FETCH;
                        k_r        <= 4'd0;
                        ram_rd_r   <= 1'b1;
                        ram_addr_r <= addr_s;
                    end
                end
                ST_FETCH: begin
                    // Read data lags the strobe by one cycle, so tap k-1 lands while tap k is read.
                    if (k_r != 4'd0) begin
                        win_r[k_r - 4'd1] <= ram_dout;
                    end
                    if (k_r == 4'd8) begin
                        state_r  <= ST_CAP;
                        ram_rd_r <= 1'b0;
                    end else begin
                        k_r        <= k_r + 4'd1;
                        ram_addr_r <= addr_s;
                    end
                end
                ST_CAP: begin
                    win_r[8]  <= ram_dout;
                    state_r   <= ST_PRESENT;
                    win_vld_r <= 1'b1;
                end
                ST_PRESENT: begin
                    if (win_rdy) begin
                        win_vld_r <= 1'b0;
                        if (last_s) begin
                            state_r    <= ST_IDLE;
                            busy_r     <= 1'b0;
                            frm_done_r <= 1'b1;
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    ram_rd_r  <= 1'b0;
                    win_vld_r <= 1'b0;
                end
            endcase
        end
    end

    assign ram_rd   = ram_rd_r;
    assign ram_addr = ram_addr_r;
    assign win      = win_r;
    assign win_vld  = win_vld_r;
    assign busy     = busy_r;
    assign frm_done = frm_done_r;

endmodule

// File: tb/tb_cnn_win_sched.sv
// Scoreboard bench for cnn_win_sched: expected addresses/windows queued by stimulus, checked by monitors.
module tb_cnn_win_sched;

    localparam int W  = 28;
    localparam int H  = 28;
    localparam int AW = 10;
    // Hand-computed window at origin (0,0) for pix(a) = a0^a2^a5^a7.
    localparam logic [8:0] WIN00 = 9'b101101010;

    logic          clk = 1'b0;
    logic          rst;
    logic          frm_strt;
    logic [AW-1:0] wr_ptr;
    logic          ram_rd;
    logic [AW-1:0] ram_addr;
    logic          ram_dout;
    logic [8:0]    win;
    logic          win_vld;
    logic          win_rdy;
    logic          busy;
    logic          frm_done;

    int cmp_cnt  = 0;
    int err_cnt  = 0;
    int hs_cnt   = 0;
    int done_cnt = 0;

    logic [AW-1:0] addr_q[$];
    logic [8:0]    win_q[$];
    logic [AW-1:0] exp_a_m;
    logic [8:0]    exp_w_m;

    cnn_win_sched #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .frm_strt (frm_strt),
        .wr_ptr   (wr_ptr),
        .ram_rd   (ram_rd),
        .ram_addr (ram_addr),
        .ram_dout (ram_dout),
        .win      (win),
        .win_vld  (win_vld),
        .win_rdy  (win_rdy),
        .busy     (busy),
        .frm_done (frm_done)
    );

    always #5 clk = ~clk;

    function automatic logic pix(input int a);
        logic [9:0] v;
        v = a[9:0];
        return v[0] ^ v[2] ^ v[5] ^ v[7];
    endfunction

    // Bit RAM: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (rst) ram_dout <= 1'b0;
        else if (ram_rd) ram_dout <= pix(int'(ram_addr));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Queue the first nrd tap addresses of window (r,c) and optionally its expected contents.
    task automatic push_win(input int r, input int c, input int nrd, input bit with_win);
        logic [8:0] w;
        int a;
        for (int k = 0; k < 9; k++) begin
            a = (r + k / 3) * W + c + k % 3;
            if (k < nrd) addr_q.push_back(a[AW-1:0]);
            w[k] = pix(a);
        end
        if (with_win) win_q.push_back(w);
    endtask

    // Read-address monitor.
    always @(negedge clk) begin
        if (ram_rd) begin
            cmp_cnt++;
            if (addr_q.size() == 0) begin
                err_cnt++;
                $display("FAIL unexpected_read: got addr %0d expected no read", ram_addr);
            end else begin
                exp_a_m = addr_q.pop_front();
                if (ram_addr !== exp_a_m) begin
                    err_cnt++;
                    $display("FAIL ram_addr: got %0d expected %0d", ram_addr, exp_a_m);
                end
            end
        end
    end

    // Window handshake monitor and frame-done counter.
    always @(negedge clk) begin
        if (win_vld && win_rdy) begin
            hs_cnt++;
            cmp_cnt++;
            if (win_q.size() == 0) begin
                err_cnt++;
                $display("FAIL unexpected_window: got %b expected none", win);
            end else begin
                exp_w_m = win_q.pop_front();
                if (win !== exp_w_m) begin
                    err_cnt++;
                    $display("FAIL window: got %b expected %b", win, exp_w_m);
                end
            end
        end
        if (frm_done) done_cnt++;
    end

    initial begin
        int lat;
        int hs0;
        int d0;
        bit seen;

        rst = 1'b1; frm_strt = 1'b0; wr_ptr = '0; win_rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_win", win, 0);
        check("rst_win_vld", win_vld, 0);
        check("rst_busy", busy, 0);
        check("rst_ram_rd", ram_rd, 0);
        check("rst_frm_done", frm_done, 0);

        // Data not yet far enough: no reads while wr_ptr = 58.
        @(posedge clk); #1 rst = 1'b0; wr_ptr = 10'd58; frm_strt = 1'b1;
        @(posedge clk); #1 frm_strt = 1'b0;
        repeat (20) @(negedge clk);
        check("wait58_no_rd", ram_rd, 0);
        check("wait58_busy", busy, 1);

        // wr_ptr = 59 releases the first window on the next edge.
        @(posedge clk); #1 push_win(0, 0, 9, 1'b1); wr_ptr = 10'd59;
        @(negedge clk);
        check("rd_before_go", ram_rd, 0);
        @(negedge clk);
        check("fetch_next_cycle", ram_rd, 1);
        check("first_addr", ram_addr, 0);
        lat = 0;
        while (!win_vld && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("win_vld_latency", lat, 10);
        check("win00", win, WIN00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_win", win, WIN00);
            check("hold_vld", win_vld, 1);
            check("hold_no_rd", ram_rd, 0);
        end
        @(posedge clk); #1 win_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("vld_drop_after_hs", win_vld, 0);
        repeat (3) @(negedge clk);
        check("wait59_no_rd", ram_rd, 0);
        check("wait59_busy", busy, 1);

        // Abort during FETCH of window (0,1) at tap 4, then run a full frame.
        @(posedge clk); #1 push_win(0, 1, 5, 1'b0); wr_ptr = 10'd784;
        repeat (5) @(posedge clk);
        #1 check("abort_at_k4_addr", ram_addr, 30);
        check("abort_at_k4_rd", ram_rd, 1);
        frm_strt = 1'b1;
        for (int r = 0; r < H - 2; r++)
            for (int c = 0; c < W - 2; c++)
                push_win(r, c, 9, 1'b1);
        hs0 = hs_cnt;
        d0  = done_cnt;
        @(posedge clk); #1 frm_strt = 1'b0;
        @(negedge clk);
        check("abort_no_vld", win_vld, 0);
        check("abort_no_rd", ram_rd, 0);
        check("abort_busy", busy, 1);
        seen = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (frm_done) begin
                seen = 1'b1;
                break;
            end
        end
        check("frame_done_seen", seen, 1);
        check("done_busy", busy, 0);
        @(negedge clk);
        check("after_done_busy", busy, 0);
        check("done_single_cycle", frm_done, 0);
        repeat (3) @(negedge clk);
        check("frame_handshakes", hs_cnt - hs0, 676);
        check("frame_done_pulses", done_cnt - d0, 1);
        check("win_q_empty", win_q.size(), 0);
        check("addr_q_empty", addr_q.size(), 0);

        // Reset while a window is presented.
        @(posedge clk); #1 win_rdy = 1'b0; frm_strt = 1'b1; push_win(0, 0, 9, 1'b0);
        @(posedge clk); #1 frm_strt = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (win_vld) begin
                seen = 1'b1;
                break;
            end
        end
        check("present_seen", seen, 1);
        check("present_win00", win, WIN00);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rstp_win", win, 0);
        check("rstp_vld", win_vld, 0);
        check("rstp_busy", busy, 0);
        @(posedge clk); #1 win_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rstp_idle_vld", win_vld, 0);
            check("rstp_idle_busy", busy, 0);
        end
        check("final_addr_q_empty", addr_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
